// File: rtl/syn_vga_drvr_lb_ctrl.sv
// Purpose : local-bus control/status for the VGA driver: enable FSM, sticky
//           line-buffer error status, saturating error counters, error irq.
// Latency : register access acked one cycle after the strobe; vga_drvr_en_o
//           and err_irq_o follow the causing write or event by one cycle.
// Backpr. : none; every strobe is acked unconditionally, no stall path.
// Ports   : clk_ir/rst_ih clock and sync reset; lb_* local-bus strobes, address,
//           write data, acks and read data; bffr_* line-buffer level flags;
//           vga_drvr_en_o driver enable; err_irq_o unmasked sticky error OR.
module syn_vga_drvr_lb_ctrl #(
  parameter int LB_DATA_W = 32,
  parameter int LB_ADDR_W = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_ir,
  input  logic                 rst_ih,
  input  logic                 lb_wr_en_i,
  input  logic                 lb_rd_en_i,
  input  logic [LB_ADDR_W-1:0] lb_addr_i,
  input  logic [LB_DATA_W-1:0] lb_wr_data_i,
  output logic                 lb_wr_valid_o,
  output logic                 lb_rd_valid_o,
  output logic [LB_DATA_W-1:0] lb_rd_data_o,
  input  logic                 bffr_overflow_i,
  input  logic                 bffr_underflow_i,
  output logic                 vga_drvr_en_o,
  output logic                 err_irq_o
);

  typedef enum logic [1:0] {
    ST_DIS  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_drvr_en;
  logic [3:0]           r_ctrl;       // [0] en_req [1] auto_halt [2] mask_ovf [3] mask_unf
  logic                 r_ovf_st;
  logic                 r_unf_st;
  logic [CNT_W-1:0]     r_ovf_cnt;
  logic [CNT_W-1:0]     r_unf_cnt;
  logic                 r_ovf_prev;
  logic                 r_unf_prev;
  logic                 r_wr_vld;
  logic                 r_rd_vld;
  logic [LB_DATA_W-1:0] r_rd_data;
  logic                 r_irq;

  logic [2:0]           w_addr;
  logic                 w_wr_ctrl, w_wr_stat, w_wr_ovfc, w_wr_unfc;
  logic                 w_ovf_ev, w_unf_ev, w_any_ev;
  logic [3:0]           w_ctrl_nxt;
  logic                 w_ovf_st_nxt, w_unf_st_nxt;
  logic [CNT_W-1:0]     w_ovf_cnt_nxt, w_unf_cnt_nxt;
  logic [LB_DATA_W-1:0] w_rd_mux;
  logic                 w_unused_bits;

  // Only the low three address bits decode; upper address and data bits are don't-care.
  assign w_addr        = lb_addr_i[2:0];
  assign w_unused_bits = ^{lb_addr_i[LB_ADDR_W-1:3], lb_wr_data_i[LB_DATA_W-1:4]};

  assign w_wr_ctrl = lb_wr_en_i && (w_addr == 3'd0);
  assign w_wr_stat = lb_wr_en_i && (w_addr == 3'd1);
  assign w_wr_ovfc = lb_wr_en_i && (w_addr == 3'd2);
  assign w_wr_unfc = lb_wr_en_i && (w_addr == 3'd3);

  assign w_ovf_ev = bffr_overflow_i  & ~r_ovf_prev;
  assign w_unf_ev = bffr_underflow_i & ~r_unf_prev;
  assign w_any_ev = w_ovf_ev | w_unf_ev;

  assign w_ctrl_nxt = w_wr_ctrl ? lb_wr_data_i[3:0] : r_ctrl;

  // An event in the same cycle as a W1C write keeps the sticky bit set.
  assign w_ovf_st_nxt = w_ovf_ev | (r_ovf_st & ~(w_wr_stat & lb_wr_data_i[0]));
  assign w_unf_st_nxt = w_unf_ev | (r_unf_st & ~(w_wr_stat & lb_wr_data_i[1]));

  // Clear first, then count: an event coinciding with a clear-write lands at 1.
  always_comb begin
    w_ovf_cnt_nxt = r_ovf_cnt;
    if (w_wr_ovfc) w_ovf_cnt_nxt = '0;
    if (w_ovf_ev && (w_ovf_cnt_nxt != {CNT_W{1'b1}})) w_ovf_cnt_nxt = w_ovf_cnt_nxt + CNT_W'(1);
  end

  always_comb begin
    w_unf_cnt_nxt = r_unf_cnt;
    if (w_wr_unfc) w_unf_cnt_nxt = '0;
    if (w_unf_ev && (w_unf_cnt_nxt != {CNT_W{1'b1}})) w_unf_cnt_nxt = w_unf_cnt_nxt + CNT_W'(1);
  end

  // Read mux sees current (pre-write) register contents.
  always_comb begin
    w_rd_mux = '0;
    case (w_addr)
      3'd0:    w_rd_mux[3:0]       = r_ctrl;
      3'd1:    w_rd_mux[3:0]       = {r_state, r_unf_st, r_ovf_st};
      3'd2:    w_rd_mux[CNT_W-1:0] = r_ovf_cnt;
      3'd3:    w_rd_mux[CNT_W-1:0] = r_unf_cnt;
      default: w_rd_mux            = '0;
    endcase
  end

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      r_ctrl     <= '0;
      r_ovf_st   <= 1'b0;
      r_unf_st   <= 1'b0;
      r_ovf_cnt  <= '0;
      r_unf_cnt  <= '0;
      r_ovf_prev <= 1'b0;
      r_unf_prev <= 1'b0;
      r_wr_vld   <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_data  <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_ovf_st   <= w_ovf_st_nxt;
      r_unf_st   <= w_unf_st_nxt;
      r_ovf_cnt  <= w_ovf_cnt_nxt;
      r_unf_cnt  <= w_unf_cnt_nxt;
      r_ovf_prev <= bffr_overflow_i;
      r_unf_prev <= bffr_underflow_i;
      r_wr_vld   <= lb_wr_en_i;
      r_rd_vld   <= lb_rd_en_i;
      r_rd_data  <= lb_rd_en_i ? w_rd_mux : '0;
      r_irq      <= (w_ovf_st_nxt & ~w_ctrl_nxt[2]) | (w_unf_st_nxt & ~w_ctrl_nxt[3]);
    end
  end

  // Driver FSM acts on the post-write CTRL value so the enable moves one
  // cycle after the CTRL write. HALT is left only by dropping en_req.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      r_state   <= ST_DIS;
      r_drvr_en <= 1'b0;
    end else begin
      case (r_state)
        ST_DIS: begin
          if (w_ctrl_nxt[0]) begin
            r_state   <= ST_RUN;
            r_drvr_en <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_ctrl_nxt[0]) begin
            r_state   <= ST_DIS;
            r_drvr_en <= 1'b0;
          end else if (w_ctrl_nxt[1] && w_any_ev) begin
            r_state   <= ST_HALT;
            r_drvr_en <= 1'b0;
          end
        end
        ST_HALT: begin
          r_drvr_en <= 1'b0;
          if (!w_ctrl_nxt[0]) r_state <= ST_DIS;
        end
        default: begin
          r_state   <= ST_DIS;
          r_drvr_en <= 1'b0;
        end
      endcase
    end
  end

  assign lb_wr_valid_o = r_wr_vld;
  assign lb_rd_valid_o = r_rd_vld;
  assign lb_rd_data_o  = r_rd_data;
  assign vga_drvr_en_o = r_drvr_en;
  assign err_irq_o     = r_irq;

endmodule

// File: tb/tb_syn_vga_drvr_lb_ctrl.sv
// Purpose : randomized + directed scoreboard bench for syn_vga_drvr_lb_ctrl.
// Latency : expected responses queued at stimulus time, compared one edge later.
// Backpr. : none; the DUT never stalls, so every cycle yields one expected entry.
module tb_syn_vga_drvr_lb_ctrl;
  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk_ir = 1'b0;
  logic          rst_ih = 1'b1;
  logic          lb_wr_en_i = 1'b0, lb_rd_en_i = 1'b0;
  logic [AW-1:0] lb_addr_i = '0;
  logic [DW-1:0] lb_wr_data_i = '0;
  logic          lb_wr_valid_o, lb_rd_valid_o;
  logic [DW-1:0] lb_rd_data_o;
  logic          bffr_overflow_i = 1'b0, bffr_underflow_i = 1'b0;
  logic          vga_drvr_en_o, err_irq_o;

  syn_vga_drvr_lb_ctrl #(.LB_DATA_W(DW), .LB_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_ir(clk_ir), .rst_ih(rst_ih),
    .lb_wr_en_i(lb_wr_en_i), .lb_rd_en_i(lb_rd_en_i),
    .lb_addr_i(lb_addr_i), .lb_wr_data_i(lb_wr_data_i),
    .lb_wr_valid_o(lb_wr_valid_o), .lb_rd_valid_o(lb_rd_valid_o),
    .lb_rd_data_o(lb_rd_data_o),
    .bffr_overflow_i(bffr_overflow_i), .bffr_underflow_i(bffr_underflow_i),
    .vga_drvr_en_o(vga_drvr_en_o), .err_irq_o(err_irq_o)
  );

  always #5 clk_ir = ~clk_ir;

  typedef struct {
    bit wr;
    bit rd;
    bit en;
    bit irq;
  } sig_t;

  sig_t        sig_q[$];
  int unsigned rd_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model: architectural register view.
  bit [3:0] m_ctrl;
  bit       m_ovf_st, m_unf_st, m_povf, m_punf;
  int       m_ovf_cnt, m_unf_cnt;
  int       m_state;   // 0 DIS, 1 RUN, 2 HALT

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_ovf_st = 0; m_unf_st = 0; m_povf = 0; m_punf = 0;
    m_ovf_cnt = 0; m_unf_cnt = 0; m_state = 0;
  endtask

  // One bus cycle: drive inputs at negedge, advance the model, queue expectations.
  task automatic cyc(input bit rst, input bit wr, input bit rd, input logic [7:0] addr,
                     input logic [31:0] dat, input bit ovf, input bit unf);
    sig_t        s;
    bit          ovf_ev, unf_ev;
    int unsigned v;
    @(negedge clk_ir);
    rst_ih = rst; lb_wr_en_i = wr; lb_rd_en_i = rd; lb_addr_i = addr;
    lb_wr_data_i = dat; bffr_overflow_i = ovf; bffr_underflow_i = unf;
    if (rst) begin
      model_reset();
      s = '{wr: 0, rd: 0, en: 0, irq: 0};
    end else begin
      ovf_ev = ovf && !m_povf;
      unf_ev = unf && !m_punf;
      m_povf = ovf;
      m_punf = unf;
      if (rd) begin
        case (addr[2:0])
          3'd0:    v = m_ctrl;
          3'd1:    v = m_ovf_st + 2 * m_unf_st + 4 * m_state;
          3'd2:    v = m_ovf_cnt;
          3'd3:    v = m_unf_cnt;
          default: v = 0;
        endcase
        rd_q.push_back(v);
      end
      if (wr) begin
        case (addr[2:0])
          3'd0: m_ctrl = dat[3:0];
          3'd1: begin
            if (dat[0]) m_ovf_st = 0;
            if (dat[1]) m_unf_st = 0;
          end
          3'd2: m_ovf_cnt = 0;
          3'd3: m_unf_cnt = 0;
          default: ;
        endcase
      end
      if (ovf_ev) begin m_ovf_st = 1; if (m_ovf_cnt < MAXC) m_ovf_cnt++; end
      if (unf_ev) begin m_unf_st = 1; if (m_unf_cnt < MAXC) m_unf_cnt++; end
      if (!m_ctrl[0])                                    m_state = 0;
      else if (m_state == 0)                             m_state = 1;
      else if (m_state == 1 && m_ctrl[1] && (ovf_ev || unf_ev)) m_state = 2;
      s.wr  = wr;
      s.rd  = rd;
      s.en  = (m_state == 1);
      s.irq = (m_ovf_st && !m_ctrl[2]) || (m_unf_st && !m_ctrl[3]);
    end
    sig_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cyc(0, 1, 0, a, d, 0, 0);
  endtask
  task automatic rd(input logic [7:0] a);
    cyc(0, 0, 1, a, 0, 0, 0);
  endtask
  task automatic pulse_ovf();
    cyc(0, 0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic pulse_unf();
    cyc(0, 0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected entry per clock; read data popped when the DUT presents it.
  always @(posedge clk_ir) begin
    #1;
    if (sig_q.size() > 0) begin
      sig_t e;
      e = sig_q.pop_front();
      chk("wr_valid", 32'(lb_wr_valid_o), 32'(e.wr));
      chk("rd_valid", 32'(lb_rd_valid_o), 32'(e.rd));
      chk("drvr_en",  32'(vga_drvr_en_o), 32'(e.en));
      chk("err_irq",  32'(err_irq_o),     32'(e.irq));
      if (!e.rd) chk("rd_data_idle", lb_rd_data_o, 32'd0);
    end
    if (lb_rd_valid_o === 1'b1) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else                  chk("rd_data", lb_rd_data_o, rd_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ovf_l, unf_l;
    model_reset();
    cyc(1, 1, 1, 0, 32'hF, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 5; a++) rd(8'(a));

    wr(0, 1); rd(1);
    for (int i = 0; i < 3; i++) pulse_ovf();
    rd(2); rd(1); wr(1, 1); idle(1); rd(1);

    wr(0, 3); pulse_unf(); rd(1); wr(0, 0); rd(1); wr(0, 1); rd(1);

    for (int i = 0; i < MAXC + 5; i++) pulse_ovf();
    rd(2); pulse_ovf(); rd(2); wr(2, 0); rd(2);

    cyc(0, 1, 0, 1, 1, 1, 0); cyc(0, 0, 0, 0, 0, 0, 0); rd(1);
    cyc(0, 1, 0, 2, 0, 1, 0); cyc(0, 0, 0, 0, 0, 0, 0); rd(2);
    cyc(0, 1, 1, 0, 5, 0, 0); rd(0);
    rd(8'hF9); rd(8'h07); wr(8'h05, 32'hFFFF_FFFF); rd(0);
    cyc(0, 1, 1, 1, 0, 0, 0); cyc(1, 1, 1, 0, 0, 0, 0); idle(2);

    ovf_l = 0; unf_l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) ovf_l = ~ovf_l;
      if ($urandom_range(3) == 0) unf_l = ~unf_l;
      cyc(($urandom_range(199) == 0), ($urandom_range(3) == 0), ($urandom_range(2) == 0),
          8'($urandom), $urandom, ovf_l, unf_l);
    end
    idle(2);
    @(posedge clk_ir); #3;
    chk("drain_sig", 32'(sig_q.size()), 32'd0);
    chk("drain_rd",  32'(rd_q.size()),  32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
